// File: rtl/switch_ingress_fifo.sv
// Ingress buffer in front of the address-routing switch: a circular FIFO that
// replays accepted {addr, data} entries as registered beats with an optional idle gap.
module switch_ingress_fifo #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int GAP        = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     pause,
  output logic                     vld,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [DATA_WIDTH-1:0]    data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP);

  logic [EW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  push, pop;
  logic [EW-1:0]         head;

  // Readiness comes only from registered occupancy, so a pop never frees a slot
  // for a push on the same edge.
  assign in_ready = (level_q != FULL_LEVEL);
  assign push     = in_valid && in_ready;
  assign pop      = (level_q != '0) && !pause && (gap_q == '0);
  assign head     = mem_q[rptr_q];

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    gap_d   = gap_q;
    vld_d   = 1'b0;
    addr_d  = '0;
    data_d  = '0;

    if (push) wptr_d = wptr_q + 1'b1;

    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      gap_d  = GAP_LOAD;
      vld_d  = 1'b1;
      addr_d = head[EW-1:DATA_WIDTH];
      data_d = head[DATA_WIDTH-1:0];
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the same pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      gap_q   <= '0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      gap_q   <= gap_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; entries are only read
  // once level says they were written, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {in_addr, in_data};
  end

  assign vld   = vld_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign level = level_q;

endmodule

// File: tb/tb_switch_ingress_fifo.sv
// Self-checking bench for switch_ingress_fifo: directed scenarios plus random traffic,
// compared against a queue-based reference model, on a GAP=0 and a GAP=2 instance.
module tb_switch_ingress_fifo;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid, pause, sel;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  logic          in_valid0, in_valid1;
  logic          in_ready0, in_ready1, vld0, vld1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic [3:0]    level0, level1;

  logic          obs_ready, obs_vld;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_data;
  logic [3:0]    obs_level;

  always #5 clk = ~clk;

  assign in_valid0 = in_valid && !sel;
  assign in_valid1 = in_valid && sel;
  assign obs_ready = sel ? in_ready1 : in_ready0;
  assign obs_vld   = sel ? vld1 : vld0;
  assign obs_addr  = sel ? addr1 : addr0;
  assign obs_data  = sel ? data1 : data0;
  assign obs_level = sel ? level1 : level0;

  switch_ingress_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP(0)) dut0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_addr(in_addr), .in_data(in_data), .pause(pause),
    .vld(vld0), .addr(addr0), .data(data0), .level(level0)
  );

  switch_ingress_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP(2)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_addr(in_addr), .in_data(in_data), .pause(pause),
    .vld(vld1), .addr(addr1), .data(data1), .level(level1)
  );

  // Reference model: contents as a queue, pops allowed from a cycle stamp.
  logic [AW+DW-1:0] mq [$];
  int               cyc, next_ok, gap;
  logic             accepted;
  int               vectors = 0;
  int               miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic             push, pop;
    logic [AW+DW-1:0] e;
    logic [AW-1:0]    ea;
    logic [DW-1:0]    ed;
    push = in_valid && (mq.size() != DEPTH);
    pop  = (mq.size() != 0) && !pause && (cyc >= next_ok);
    e    = {in_addr, in_data};
    accepted = push;
    @(posedge clk);
    #1;
    ea = '0;
    ed = '0;
    if (pop) begin
      {ea, ed} = mq.pop_front();
      next_ok = cyc + gap + 1;
    end
    if (push) mq.push_back(e);
    cyc++;
    check("vld",      32'(obs_vld),   32'(pop));
    check("addr",     32'(obs_addr),  32'(ea));
    check("data",     32'(obs_data),  32'(ed));
    check("level",    32'(obs_level), 32'(mq.size()));
    check("in_ready", 32'(obs_ready), 32'(mq.size() != DEPTH));
  endtask

  task automatic model_reset();
    mq.delete();
    next_ok = 0;
  endtask

  task automatic reset_cycle();
    in_valid = 1'b0;
    pause    = 1'b0;
    rstn     = 1'b0;
    #1;
    model_reset();
    check("rst_vld",   32'(obs_vld),   32'd0);
    check("rst_addr",  32'(obs_addr),  32'd0);
    check("rst_data",  32'(obs_data),  32'd0);
    check("rst_level", 32'(obs_level), 32'd0);
    check("rst_ready", 32'(obs_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            k;
    logic [AW-1:0] got [$];
    logic [9:0]    pat;

    sel = 1'b0; gap = 0; cyc = 0; in_addr = '0; in_data = '0;
    in_valid = 1'b0; pause = 1'b0; rstn = 1'b0;
    #2;
    reset_cycle();

    // Single write: level after E, beat after E+1, zeroed after E+2.
    in_valid = 1'b1; in_addr = 8'h12; in_data = 16'hABCD;
    step();
    check("single_level", 32'(obs_level), 32'd1);
    in_valid = 1'b0;
    step();
    check("single_vld",  32'(obs_vld),  32'd1);
    check("single_addr", 32'(obs_addr), 32'h12);
    check("single_data", 32'(obs_data), 32'hABCD);
    step();
    check("single_idle", 32'(obs_vld), 32'd0);

    // Fill to full under pause; the 9th beat is held by the producer.
    pause = 1'b1; k = 0;
    for (int n = 0; n < 9; n++) begin
      in_valid = 1'b1; in_addr = AW'(k); in_data = DW'($urandom);
      step();
      if (accepted) k++;
    end
    check("full_level", 32'(obs_level), 32'd8);
    check("full_ready", 32'(obs_ready), 32'd0);
    check("full_held",  32'(k),         32'd8);

    pause = 1'b0;
    for (int n = 0; n < 40 && got.size() < 9; n++) begin
      in_valid = (k < 9);
      in_addr  = AW'(k);
      in_data  = DW'($urandom);
      step();
      if (accepted) k++;
      if (obs_vld) got.push_back(obs_addr);
    end
    in_valid = 1'b0;
    check("drain_count", 32'(got.size()), 32'd9);
    for (int i = 0; i < got.size(); i++) check("drain_order", 32'(got[i]), 32'(i));

    // Steady streaming at level 3 across several pointer wraps.
    reset_cycle();
    pause = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1; in_addr = AW'($urandom); in_data = DW'($urandom);
      step();
    end
    pause = 1'b0;
    for (int n = 0; n < 24; n++) begin
      in_addr = AW'($urandom); in_data = DW'($urandom);
      step();
      check("stream_level", 32'(obs_level), 32'd3);
    end
    in_valid = 1'b0;
    for (int n = 0; n < 5; n++) step();

    // Asynchronous reset while level=5 and a beat is on vld.
    pause = 1'b1;
    for (int n = 0; n < 6; n++) begin
      in_valid = 1'b1; in_addr = AW'(8'h40 + n); in_data = DW'($urandom);
      step();
    end
    in_valid = 1'b0; pause = 1'b0;
    step();
    check("pre_rst_vld",   32'(obs_vld),   32'd1);
    check("pre_rst_level", 32'(obs_level), 32'd5);
    #2;
    reset_cycle();
    for (int n = 0; n < 6; n++) begin
      step();
      check("no_stale_vld", 32'(obs_vld), 32'd0);
    end

    // Random traffic on the back-to-back instance.
    for (int n = 0; n < 300; n++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      pause    = ($urandom_range(0, 9) < 2);
      in_addr  = AW'($urandom);
      in_data  = DW'($urandom);
      step();
    end

    // GAP=2 instance: beat spacing, pause toggled inside the gap.
    sel = 1'b1; gap = 2;
    reset_cycle();
    pause = 1'b1;
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1; in_addr = AW'(8'h80 + n); in_data = DW'($urandom);
      step();
    end
    in_valid = 1'b0;
    pat = '0;
    for (int n = 0; n < 10; n++) begin
      pause = (cyc < next_ok) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      pat = {pat[8:0], obs_vld};
    end
    check("gap_pattern", 32'(pat), 32'(10'b1001001001));

    for (int n = 0; n < 200; n++) begin
      in_valid = ($urandom_range(0, 9) < 5);
      pause    = ($urandom_range(0, 9) < 2);
      in_addr  = AW'($urandom);
      in_data  = DW'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
